// File: rtl/sqr_arbiter.sv
// Four-way round-robin front end for a shared external half-precision squarer.
// One operation in flight: grant, present operand, capture result, hold response.
module sqr_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_data,
  output logic [3:0]  req_ready,
  output logic [15:0] sq_in,
  input  logic [15:0] sq_out,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic [1:0]  resp_id,
  input  logic        resp_ready,
  output logic        busy,
  output logic [15:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_grant;
  logic [1:0]  grant_idx;
  logic        grant_hit;
  logic        take;
  logic [15:0] operand;
  logic [15:0] resp_q;
  logic [1:0]  id_q;
  logic [15:0] ops_cnt;

  // Priority starts one past the previous winner; i == 4 wraps back to it last.
  always_comb begin
    grant_hit = 1'b0;
    grant_idx = last_grant;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!grant_hit && req_valid[last_grant + 2'(i)]) begin
        grant_hit = 1'b1;
        grant_idx = last_grant + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    take       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_hit) begin
          req_ready[grant_idx] = rst_n;
          take                 = 1'b1;
          state_nxt            = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 2'd3;
      operand    <= '0;
      resp_q     <= '0;
      id_q       <= '0;
      ops_cnt    <= '0;
    end else begin
      if (take) begin
        operand    <= req_data[{grant_idx, 4'b0000} +: 16];
        id_q       <= grant_idx;
        last_grant <= grant_idx;
      end
      // Zero exponent (zero/subnormal) bypasses the squarer result.
      if (state == CAPTURE)
        resp_q <= (operand[14:10] == 5'd0) ? '0 : sq_out;
      if (state == RESP && resp_ready)
        ops_cnt <= ops_cnt + 16'd1;
    end
  end

  assign sq_in     = operand;
  assign resp_data = resp_q;
  assign resp_id   = id_q;
  assign ops_done  = ops_cnt;

endmodule

// File: tb/tb_sqr_arbiter.sv
// Directed bench for sqr_arbiter with a toy registered squarer model attached.
module tb_sqr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic [15:0] sq_in;
  logic [15:0] sq_out;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic        busy;
  logic [15:0] ops_done;

  int unsigned vectors;
  int unsigned miscompares;

  sqr_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .sq_in      (sq_in),
    .sq_out     (sq_out),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Toy squarer: exponent 2e-15 (clamped), mantissa XOR 0x150, zero exponent
  // yields a deliberately nonzero value so a missing bypass is visible.
  function automatic logic [15:0] sq_model(input logic [15:0] x);
    int e;
    e = int'(x[14:10]);
    if (e == 0) return 16'h7BFF;
    e = 2 * e - 15;
    if (e < 1)  e = 1;
    if (e > 30) e = 30;
    return {1'b0, 5'(e), x[9:0] ^ 10'h150};
  endfunction

  always @(posedge clk) sq_out <= sq_model(sq_in);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic [1:0] id, input logic [15:0] data);
    check({tag, "_valid"}, 16'(resp_valid), 16'd1);
    check({tag, "_id"},    16'(resp_id),    16'(id));
    check({tag, "_data"},  resp_data,       data);
  endtask

  logic [15:0] exp_rr [4];
  logic [1:0]  rid;
  logic [3:0]  onehot;

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_rr[0] = 16'h4550;  // 4000
    exp_rr[1] = 16'h3D50;  // 3C00
    exp_rr[2] = 16'h4750;  // 4200
    exp_rr[3] = 16'h4D50;  // 4400
    rst_n      = 1'b0;
    req_valid  = 4'b0001;
    req_data   = '0;
    resp_ready = 1'b0;
    tick(); tick(); tick();

    // Reset values, with a request pending during reset
    check("rst_req_ready",  16'(req_ready),  16'd0);
    check("rst_resp_valid", 16'(resp_valid), 16'd0);
    check("rst_busy",       16'(busy),       16'd0);
    check("rst_ops_done",   ops_done,        16'd0);
    check("rst_resp_data",  resp_data,       16'd0);
    check("rst_resp_id",    16'(resp_id),    16'd0);
    check("rst_sq_in",      sq_in,           16'd0);
    req_valid = 4'b0000;
    rst_n     = 1'b1;
    tick();

    // Single request, 3-cycle latency
    req_valid       = 4'b0001;
    req_data[15:0]  = 16'h4000;
    #1;
    check("single_grant", 16'(req_ready), 16'h0001);
    tick();
    req_valid = 4'b0000;
    check("single_issue_ready", 16'(req_ready), 16'd0);
    check("single_busy",        16'(busy),      16'd1);
    check("single_sq_in",       sq_in,          16'h4000);
    check("single_issue_rv",    16'(resp_valid), 16'd0);
    tick();
    check("single_capture_rv",  16'(resp_valid), 16'd0);
    tick();
    check_resp("single", 2'd0, 16'h4550);
    resp_ready = 1'b1;
    tick();
    check("single_done_rv",  16'(resp_valid), 16'd0);
    check("single_ops_done", ops_done,        16'd1);
    resp_ready = 1'b0;

    // Round-robin from reset: 0,1,2,3,0 spaced four cycles apart
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    tick();
    req_data   = {16'h4400, 16'h4200, 16'h3C00, 16'h4000};
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      rid    = 2'(n);
      onehot = 4'b0001 << rid;
      check("rr_grant", 16'(req_ready), 16'(onehot));
      tick();
      check("rr_issue_ready", 16'(req_ready), 16'd0);
      tick();
      check("rr_capture_ready", 16'(req_ready), 16'd0);
      tick();
      check_resp("rr", rid, exp_rr[rid]);
      check("rr_resp_ready", 16'(req_ready), 16'd0);
      tick();
    end
    check("rr_ops_done", ops_done, 16'd5);

    // Backpressure in RESP for ten cycles
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    #1;
    check("bp_grant", 16'(req_ready), 16'h0004);
    tick(); tick(); tick();
    req_valid = 4'b1111;
    for (int n = 0; n < 10; n++) begin
      check_resp("bp_hold", 2'd2, 16'h4750);
      check("bp_no_grant", 16'(req_ready), 16'd0);
      tick();
    end
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    tick();
    check("bp_idle_busy", 16'(busy),       16'd0);
    check("bp_idle_rv",   16'(resp_valid), 16'd0);
    check("bp_ops_done",  ops_done,        16'd6);
    resp_ready = 1'b0;

    // Zero/subnormal bypass
    req_data[15:0] = 16'h0000;
    req_valid      = 4'b0001;
    #1;
    check("zero_grant", 16'(req_ready), 16'h0001);
    tick();
    req_valid = 4'b0000;
    tick(); tick();
    check_resp("zero", 2'd0, 16'h0000);
    resp_ready = 1'b1;
    tick();
    resp_ready     = 1'b0;
    req_data[15:0] = 16'h0200;
    req_valid      = 4'b0001;
    #1;
    check("subn_grant", 16'(req_ready), 16'h0001);
    tick();
    req_valid = 4'b0000;
    tick(); tick();
    check_resp("subn", 2'd0, 16'h0000);
    resp_ready = 1'b1;
    tick();
    check("bypass_ops_done", ops_done, 16'd8);
    resp_ready = 1'b0;

    // Reset while in CAPTURE discards the operation
    req_data[31:16] = 16'h4000;
    req_valid       = 4'b0010;
    #1;
    check("rcap_grant", 16'(req_ready), 16'h0002);
    tick();
    req_valid = 4'b0000;
    tick();
    rst_n = 1'b0;
    #1;
    check("rcap_rv",        16'(resp_valid), 16'd0);
    check("rcap_busy",      16'(busy),       16'd0);
    check("rcap_ops_done",  ops_done,        16'd0);
    check("rcap_resp_data", resp_data,       16'd0);
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("rcap_no_resp", 16'(resp_valid), 16'd0);
    end
    req_data[15:0] = 16'h3C00;
    req_valid      = 4'b0011;
    #1;
    check("rcap_first_grant", 16'(req_ready), 16'h0001);
    tick();
    req_valid = 4'b0000;
    tick(); tick();
    check_resp("rcap_next", 2'd0, 16'h3D50);
    resp_ready = 1'b1;
    tick();
    check("rcap_ops_done_after", ops_done, 16'd1);
    resp_ready = 1'b0;

    // Completion counter wrap
    force dut.ops_cnt = 16'hFFFF;
    #1;
    release dut.ops_cnt;
    #1;
    check("wrap_preload", ops_done, 16'hFFFF);
    req_valid = 4'b0001;
    #1;
    check("wrap_grant", 16'(req_ready), 16'h0001);
    tick();
    req_valid = 4'b0000;
    tick(); tick();
    check_resp("wrap", 2'd0, 16'h3D50);
    resp_ready = 1'b1;
    tick();
    check("wrap_ops_done", ops_done, 16'h0000);
    resp_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
